set_mode_ctrl: RTL and testbench

- Front-end sequencer for the time/alarm setting datapath.
- Conditions the three raw push buttons (MODE, LOC, UP) and runs the NORMAL / SET_CLOCK / SET_ALARM mode FSM.
- Drives the set-datapath enables, the digit cursor and single-cycle increment strobes, so digit counters run synchronously on CLK instead of on button edges.
- Also produces the blink mask for the display and a commit strobe when clock setting ends.

---
 rtl/set_ctrl_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/set_mode_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_set_mode_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/set_ctrl_pkg.sv
// Shared encodings for the time/alarm set-mode sequencer.
package set_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_NORMAL    = 2'd0,
      MODE_SET_CLOCK = 2'd1,
      MODE_SET_ALARM = 2'd2
   } mode_t;

   typedef logic [1:0] loc_t;

   localparam loc_t LOC_M1  = 2'd0;
   localparam loc_t LOC_M10 = 2'd1;
   localparam loc_t LOC_H1  = 2'd2;
   localparam loc_t LOC_H10 = 2'd3;

   function automatic logic [3:0] loc_onehot(input loc_t loc);
      logic [3:0] oh;
      case (loc)
         LOC_M1:  oh = 4'b0001;
         LOC_M10: oh = 4'b0010;
         LOC_H1:  oh = 4'b0100;
         LOC_H10: oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability down-counter, press pulse.
// Raw pin is active-low; accepted level resets to released (1).
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press,
   output logic held
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] DEB_LOAD = CW'(DEB_CYCLES);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // cnt counts down while the synchronized sample disagrees with level;
   // any agreeing sample reloads it, so a bounce restarts the window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= DEB_LOAD;
         press <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= DEB_LOAD;
         end else if (cnt == '0) begin
            level <= sync2;
            cnt   <= DEB_LOAD;
            press <= ~sync2;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign held = ~level;

endmodule

// File: rtl/set_mode_ctrl.sv
// Set-mode sequencer: button conditioning, mode FSM, cursor, strobes, blink.
// Optional UP auto-repeat is built when SET_AUTO_REPEAT_EN is defined.
//
// state          | meaning
// MODE_NORMAL    | time display, LOC/UP ignored
// MODE_SET_CLOCK | editing clock digits, COMMIT on exit
// MODE_SET_ALARM | editing alarm digits, no COMMIT on exit
module set_mode_ctrl
   import set_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int BLINK_HALF     = 250,
   parameter int REPEAT_DELAY   = 200,
   parameter int REPEAT_RATE    = 50
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BT_MODE,
   input  logic       BT_LOC,
   input  logic       BT_UP,
   output logic [1:0] MODE,
   output logic       SET_CLK_EN,
   output logic       SET_ALM_EN,
   output logic [1:0] CNT_LOC,
   output logic       INC_PULSE,
   output logic [3:0] BLINK_MASK,
   output logic       COMMIT
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(BLINK_HALF + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [BW-1:0] BLK_LOAD = BW'(BLINK_HALF - 1);

   logic ev_mode, ev_loc, ev_up;
   logic mode_held, loc_held, up_held;
   logic unused_held;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
      .clk(CLK), .rst(RESET), .raw(BT_MODE), .press(ev_mode), .held(mode_held)
   );
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_loc (
      .clk(CLK), .rst(RESET), .raw(BT_LOC), .press(ev_loc), .held(loc_held)
   );
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .clk(CLK), .rst(RESET), .raw(BT_UP), .press(ev_up), .held(up_held)
   );

   mode_t         mode_q, mode_d;
   loc_t          loc_q, loc_d;
   logic          inc_q, inc_d;
   logic          commit_q, commit_d;
   logic          phase_q, phase_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [BW-1:0] blk_q, blk_d;
   logic [3:0]    mask_q, mask_d;
   logic          clk_en_q, alm_en_q;
   logic          set_act, enter, leave, activity, rpt_fire;

`ifdef SET_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DLY_LOAD  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LOAD = RW'(REPEAT_RATE - 1);

   logic          rpt_on_q, rpt_on_d;
   logic [RW-1:0] rpt_q, rpt_d;

   assign unused_held = ^{mode_held, loc_held};
`else
   assign unused_held = ^{mode_held, loc_held, up_held,
                          REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

   always_comb begin
      mode_d   = mode_q;
      loc_d    = loc_q;
      inc_d    = 1'b0;
      commit_d = 1'b0;
      phase_d  = phase_q;
      tmo_d    = tmo_q;
      blk_d    = blk_q;
      enter    = 1'b0;
      leave    = 1'b0;
      activity = 1'b0;
      set_act  = (mode_q != MODE_NORMAL);
      rpt_fire = 1'b0;
`ifdef SET_AUTO_REPEAT_EN
      rpt_fire = rpt_on_q && up_held && (rpt_q == '0);
`endif

      // Priority MODE > LOC > UP > repeat > timeout; lower ones are dropped.
      if (!set_act) begin
         if (ev_mode) begin
            mode_d = MODE_SET_CLOCK;
            enter  = 1'b1;
         end
      end else if (ev_mode) begin
         if (mode_q == MODE_SET_CLOCK) begin
            mode_d   = MODE_SET_ALARM;
            enter    = 1'b1;
            commit_d = 1'b1;
         end else begin
            mode_d = MODE_NORMAL;
            leave  = 1'b1;
         end
      end else if (ev_loc) begin
         loc_d    = loc_q + 2'd1;
         activity = 1'b1;
      end else if (ev_up || rpt_fire) begin
         inc_d    = 1'b1;
         activity = 1'b1;
      end else if (tmo_q == '0) begin
         mode_d   = MODE_NORMAL;
         leave    = 1'b1;
         commit_d = (mode_q == MODE_SET_CLOCK);
      end

      if (enter || leave)
         loc_d = LOC_M1;

      if (enter || leave || activity || !set_act) begin
         tmo_d   = TMO_LOAD;
         blk_d   = BLK_LOAD;
         phase_d = 1'b0;
      end else begin
         tmo_d = tmo_q - 1'b1;
         if (blk_q == '0) begin
            blk_d   = BLK_LOAD;
            phase_d = ~phase_q;
         end else begin
            blk_d = blk_q - 1'b1;
         end
      end

      mask_d = (mode_d != MODE_NORMAL && phase_d) ? loc_onehot(loc_d) : 4'b0000;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mode_q   <= MODE_NORMAL;
         loc_q    <= LOC_M1;
         inc_q    <= 1'b0;
         commit_q <= 1'b0;
         phase_q  <= 1'b0;
         tmo_q    <= TMO_LOAD;
         blk_q    <= BLK_LOAD;
         mask_q   <= 4'b0000;
         clk_en_q <= 1'b0;
         alm_en_q <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         loc_q    <= loc_d;
         inc_q    <= inc_d;
         commit_q <= commit_d;
         phase_q  <= phase_d;
         tmo_q    <= tmo_d;
         blk_q    <= blk_d;
         mask_q   <= mask_d;
         clk_en_q <= (mode_d == MODE_SET_CLOCK);
         alm_en_q <= (mode_d == MODE_SET_ALARM);
      end
   end

`ifdef SET_AUTO_REPEAT_EN
   // Repeat runs only while UP stays accepted-low after its own press event.
   always_comb begin
      rpt_on_d = rpt_on_q;
      rpt_d    = rpt_q;
      if (!set_act || enter || leave || ev_mode || ev_loc || !up_held) begin
         rpt_on_d = 1'b0;
         rpt_d    = DLY_LOAD;
      end else if (ev_up) begin
         rpt_on_d = 1'b1;
         rpt_d    = DLY_LOAD;
      end else if (rpt_on_q) begin
         rpt_d = (rpt_q == '0) ? RATE_LOAD : rpt_q - 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rpt_on_q <= 1'b0;
         rpt_q    <= DLY_LOAD;
      end else begin
         rpt_on_q <= rpt_on_d;
         rpt_q    <= rpt_d;
      end
   end
`endif

   assign MODE       = mode_q;
   assign SET_CLK_EN = clk_en_q;
   assign SET_ALM_EN = alm_en_q;
   assign CNT_LOC    = loc_q;
   assign INC_PULSE  = inc_q;
   assign BLINK_MASK = mask_q;
   assign COMMIT     = commit_q;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Directed bench for set_mode_ctrl; honours SET_AUTO_REPEAT_EN for the hold test.
module tb_set_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bt_mode = 1'b1, bt_loc = 1'b1, bt_up = 1'b1;
   logic [1:0] mode;
   logic       clk_en, alm_en;
   logic [1:0] cnt_loc;
   logic       inc;
   logic [3:0] mask;
   logic       commit;

   int total = 0;
   int bad = 0;
   int inc_seen = 0;
   int commit_seen = 0;
   int inc_loc_err = 0;
   logic [1:0] inc_loc_exp = 2'd0;

   always #5 clk = ~clk;

   set_mode_ctrl dut (
      .CLK(clk), .RESET(rst), .BT_MODE(bt_mode), .BT_LOC(bt_loc), .BT_UP(bt_up),
      .MODE(mode), .SET_CLK_EN(clk_en), .SET_ALM_EN(alm_en), .CNT_LOC(cnt_loc),
      .INC_PULSE(inc), .BLINK_MASK(mask), .COMMIT(commit)
   );

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (inc === 1'b1) begin
            inc_seen++;
            if (cnt_loc !== inc_loc_exp) inc_loc_err++;
         end
         if (commit === 1'b1) commit_seen++;
      end
   endtask

   // which: 0=MODE 1=LOC 2=UP
   task automatic press(input int which);
      case (which)
         0: bt_mode = 1'b0;
         1: bt_loc = 1'b0;
         default: bt_up = 1'b0;
      endcase
      step(30);
      bt_mode = 1'b1; bt_loc = 1'b1; bt_up = 1'b1;
      step(25);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
      total++; if (cnt_loc !== 2'd0) begin bad++; $display("FAIL reset_loc got=%0d want=0", cnt_loc); end
      total++; if ({inc, commit, clk_en, alm_en} !== 4'b0) begin bad++; $display("FAIL reset_strobes got=%b want=0000", {inc, commit, clk_en, alm_en}); end
      total++; if (mask !== 4'b0) begin bad++; $display("FAIL reset_mask got=%b want=0000", mask); end
      rst = 1'b0;
      step(5);
   endtask

   task automatic test_mode_cycle();
      bt_mode = 1'b0;
      step(19);
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL mode_latency_early got=%0d want=0", mode); end
      step(1);
      total++; if (mode !== 2'd1) begin bad++; $display("FAIL mode_latency got=%0d want=1", mode); end
      total++; if (clk_en !== 1'b1 || alm_en !== 1'b0) begin bad++; $display("FAIL set_clk_en got=%b%b want=10", clk_en, alm_en); end
      total++; if (cnt_loc !== 2'd0) begin bad++; $display("FAIL entry_loc got=%0d want=0", cnt_loc); end
      bt_mode = 1'b1;
      step(25);
      commit_seen = 0;
      press(0);
      total++; if (mode !== 2'd2 || alm_en !== 1'b1) begin bad++; $display("FAIL to_alarm got=%0d/%b want=2/1", mode, alm_en); end
      total++; if (commit_seen !== 1) begin bad++; $display("FAIL commit_clock_exit got=%0d want=1", commit_seen); end
      commit_seen = 0;
      press(0);
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL to_normal got=%0d want=0", mode); end
      total++; if (commit_seen !== 0) begin bad++; $display("FAIL commit_alarm_exit got=%0d want=0", commit_seen); end
   endtask

   task automatic test_loc_up();
      logic [1:0] exp_loc [5];
      exp_loc = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      press(0);
      for (int k = 0; k < 5; k++) begin
         press(1);
         total++; if (cnt_loc !== exp_loc[k]) begin bad++; $display("FAIL loc_step%0d got=%0d want=%0d", k, cnt_loc, exp_loc[k]); end
      end
      inc_seen = 0; inc_loc_err = 0; inc_loc_exp = 2'd1;
      for (int k = 0; k < 3; k++) press(2);
      total++; if (inc_seen !== 3) begin bad++; $display("FAIL up_pulses got=%0d want=3", inc_seen); end
      total++; if (inc_loc_err !== 0) begin bad++; $display("FAIL up_pulse_loc bad_pulses=%0d want=0", inc_loc_err); end
      inc_loc_exp = 2'd0;
      press(0); press(0);
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL loc_up_exit got=%0d want=0", mode); end
   endtask

   task automatic test_bounce();
      inc_seen = 0;
      press(2);
      total++; if (inc_seen !== 0 || mode !== 2'd0) begin bad++; $display("FAIL up_in_normal pulses=%0d mode=%0d want=0/0", inc_seen, mode); end
      press(0);
      inc_seen = 0;
      for (int i = 0; i < 40; i++) begin
         bt_up = ((i / 3) % 2) != 0;
         step(1);
      end
      bt_up = 1'b0; step(30); bt_up = 1'b1; step(25);
      total++; if (inc_seen !== 1) begin bad++; $display("FAIL bounce_pulses got=%0d want=1", inc_seen); end
   endtask

   task automatic test_same_cycle();
      inc_seen = 0; commit_seen = 0;
      bt_mode = 1'b0; bt_up = 1'b0;
      step(30);
      bt_mode = 1'b1; bt_up = 1'b1;
      step(25);
      total++; if (mode !== 2'd2) begin bad++; $display("FAIL same_cycle_mode got=%0d want=2", mode); end
      total++; if (commit_seen !== 1 || inc_seen !== 0) begin bad++; $display("FAIL same_cycle_strobes commit=%0d inc=%0d want=1/0", commit_seen, inc_seen); end
      press(0);
   endtask

   task automatic enter_clock(output bit found);
      found = 0;
      bt_mode = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step(1);
         if (mode === 2'd1) found = 1;
      end
      bt_mode = 1'b1;
   endtask

   task automatic test_timeout();
      bit found;
      enter_clock(found);
      total++; if (!found) begin bad++; $display("FAIL tmo_entry got=not_entered want=entered"); end
      commit_seen = 0;
      for (int j = 1; j <= 1001; j++) begin
         step(1);
         if (j == 100 || j == 600) begin
            total++; if (mask !== 4'b0000) begin bad++; $display("FAIL blink_visible_t%0d got=%b want=0000", j, mask); end
         end
         if (j == 300 || j == 800) begin
            total++; if (mask !== 4'b0001) begin bad++; $display("FAIL blink_blank_t%0d got=%b want=0001", j, mask); end
         end
         if (j == 999) begin
            total++; if (mode !== 2'd1) begin bad++; $display("FAIL tmo_early got=%0d want=1", mode); end
         end
         if (j == 1000) begin
            total++; if (mode !== 2'd0 || commit !== 1'b1) begin bad++; $display("FAIL tmo_exit mode=%0d commit=%b want=0/1", mode, commit); end
         end
         if (j == 1001) begin
            total++; if (mask !== 4'b0 || commit !== 1'b0 || commit_seen !== 1) begin bad++; $display("FAIL tmo_after mask=%b commit=%b seen=%0d want=0000/0/1", mask, commit, commit_seen); end
         end
      end
      enter_clock(found);
      for (int j = 1; j <= 1000; j++) begin
         step(1);
         if (j == 980) bt_loc = 1'b0;
      end
      total++; if (mode !== 2'd1 || cnt_loc !== 2'd1) begin bad++; $display("FAIL tmo_event_999 mode=%0d loc=%0d want=1/1", mode, cnt_loc); end
      step(20);
      bt_loc = 1'b1;
      commit_seen = 0; found = 0;
      for (int i = 0; i < 1200 && !found; i++) begin
         step(1);
         if (mode === 2'd0) found = 1;
      end
      total++; if (!found || commit_seen !== 1) begin bad++; $display("FAIL tmo_second exited=%0d commit=%0d want=1/1", found, commit_seen); end
   endtask

   task automatic test_repeat_reset();
      bit found;
      int n, tsum, exp_n, exp_sum;
`ifdef SET_AUTO_REPEAT_EN
      exp_n = 6; exp_sum = 1500;
`else
      exp_n = 1; exp_sum = 0;
`endif
      press(0);
      bt_up = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         step(1);
         if (inc === 1'b1) found = 1;
      end
      total++; if (!found) begin bad++; $display("FAIL hold_first_pulse got=none want=pulse"); end
      n = 1; tsum = 0;
      for (int t = 1; t <= 400; t++) begin
         step(1);
         if (inc === 1'b1) begin n++; tsum += t; end
      end
      total++; if (n !== exp_n) begin bad++; $display("FAIL hold_pulse_count got=%0d want=%0d", n, exp_n); end
      total++; if (tsum !== exp_sum) begin bad++; $display("FAIL hold_pulse_times sum=%0d want=%0d", tsum, exp_sum); end
      total++; if (mode !== 2'd1) begin bad++; $display("FAIL hold_mode got=%0d want=1", mode); end
      #2 rst = 1'b1;
      #1;
      total++; if ({mode, cnt_loc, mask} !== 8'h00 || {inc, commit, clk_en, alm_en} !== 4'b0) begin bad++; $display("FAIL reset_mid_hold outs=%h strobes=%b want=00/0000", {mode, cnt_loc, mask}, {inc, commit, clk_en, alm_en}); end
      commit_seen = 0;
      step(3);
      total++; if (commit_seen !== 0) begin bad++; $display("FAIL reset_no_commit got=%0d want=0", commit_seen); end
      rst = 1'b0;
      bt_up = 1'b1;
      step(5);
   endtask

   initial begin
      test_reset();
      test_mode_cycle();
      test_loc_up();
      test_bounce();
      test_same_cycle();
      test_timeout();
      test_repeat_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
